// File: rtl/sdp_march_bist.sv
// sdp_march_bist: March C- self-test controller for a simple-dual-port RAM with a 1-cycle registered read port.
// Latency: a full run keeps busy high for 11*2^ABITS cycles; done rises on the edge after the final compare.
// Backpressure: none. A start that arrives while busy is ignored. The RAM is assumed to accept a write and a read every cycle.
//
// Ports:
//   clk, rst_n                      : single clock, asynchronous active-low reset
//   start -> busy/done/fail         : run control and result
//   fail_addr/fail_elem/fail_data   : capture of the first mismatch
//   ra, wa/wd/we                    : RAM read address and write port
//   rd                              : RAM read data, valid one cycle after ra
module sdp_march_bist #(
  parameter int               ABITS   = 10,
  parameter int               DBITS   = 36,
  parameter logic [DBITS-1:0] PATTERN = {DBITS{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ABITS-1:0] fail_addr,
  output logic [2:0]       fail_elem,
  output logic [DBITS-1:0] fail_data,
  output logic [ABITS-1:0] ra,
  output logic [ABITS-1:0] wa,
  output logic [DBITS-1:0] wd,
  output logic             we,
  input  logic [DBITS-1:0] rd
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_RD, S_CMP, S_DONE} state_t;

  localparam logic [ABITS-1:0] ADDR_MAX = {ABITS{1'b1}};

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [2:0]       elem_q, elem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [ABITS-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]       fail_elem_q, fail_elem_d;
  logic [DBITS-1:0] fail_data_q, fail_data_d;
  logic [ABITS-1:0] ra_q, ra_d;
  logic [ABITS-1:0] wa_q, wa_d;
  logic [DBITS-1:0] wd_q, wd_d;
  logic             we_q, we_d;

  // Elements 2 and 4 read back the inverted background; all others read it unchanged.
  function automatic logic [DBITS-1:0] exp_word(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? ~PATTERN : PATTERN;
  endfunction

  logic desc_elem;
  logic last_addr;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    ra_d        = ra_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    we_d        = 1'b0;

    desc_elem = (elem_q == 3'd3) || (elem_q == 3'd4);
    // Terminal counts are compared directly; the counter never wraps.
    last_addr = desc_elem ? (addr_q == '0) : (addr_q == ADDR_MAX);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_W0;
          addr_d      = '0;
          elem_d      = 3'd0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          fail_data_d = '0;
        end
      end
      S_W0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_RD;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        // Only the first mismatch is kept; the run continues regardless.
        if ((rd != exp_word(elem_q)) && !fail_q) begin
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
          fail_data_d = rd;
        end
        if (!last_addr) begin
          addr_d  = desc_elem ? (addr_q - 1'b1) : (addr_q + 1'b1);
          state_d = S_RD;
        end else if (elem_q == 3'd5) begin
          state_d = S_DONE;
        end else begin
          elem_d  = elem_q + 3'd1;
          // Elements 3 and 4 walk downward from the top address.
          addr_d  = (elem_q == 3'd2 || elem_q == 3'd3) ? ADDR_MAX : '0;
          state_d = S_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d == S_W0) || (state_d == S_RD) || (state_d == S_CMP);
    done_d = (state_d == S_DONE);

    unique case (state_d)
      S_W0: begin
        we_d = 1'b1;
        wa_d = addr_d;
        wd_d = PATTERN;
      end
      S_RD: begin
        ra_d = addr_d;
      end
      S_CMP: begin
        // The write-back in elements 1-4 lands at the edge that ends the compare cycle.
        we_d = (elem_d >= 3'd1) && (elem_d <= 3'd4);
        wa_d = addr_d;
        wd_d = ~exp_word(elem_d);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      elem_q      <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
      ra_q        <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      ra_q        <= ra_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      we_q        <= we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;
  assign ra        = ra_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign we        = we_q;

endmodule

// File: tb/tb_sdp_march_bist.sv
// Bench for sdp_march_bist: two instances (background 8'h00 and 8'hA5) with 16x8 RAM models.
// The RAM model for the first instance can inject a stuck-at fault or an alias fault.
module tb_sdp_march_bist;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic       clr, stuck_en, alias_en;

  logic       a_busy, a_done, a_fail, a_we;
  logic [3:0] a_fail_addr, a_ra, a_wa;
  logic [2:0] a_fail_elem;
  logic [7:0] a_fail_data, a_wd, rd_a;

  logic       b_busy, b_done, b_fail, b_we;
  logic [3:0] b_fail_addr, b_ra, b_wa;
  logic [2:0] b_fail_elem;
  logic [7:0] b_fail_data, b_wd, rd_b;

  int vectors = 0;
  int miscompares = 0;

  sdp_march_bist #(.ABITS(4), .DBITS(8), .PATTERN(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
    .fail(a_fail), .fail_addr(a_fail_addr), .fail_elem(a_fail_elem),
    .fail_data(a_fail_data), .ra(a_ra), .wa(a_wa), .wd(a_wd), .we(a_we), .rd(rd_a)
  );

  sdp_march_bist #(.ABITS(4), .DBITS(8), .PATTERN(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .fail(b_fail), .fail_addr(b_fail_addr), .fail_elem(b_fail_elem),
    .fail_data(b_fail_data), .ra(b_ra), .wa(b_wa), .wd(b_wd), .we(b_we), .rd(rd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: 1-cycle registered read.
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 8'h00;
    end else begin
      if (a_we) mem_a[(alias_en && a_wa == 4'd11) ? 4'd3 : a_wa] <= a_wd;
      rd_a <= mem_a[a_ra] | ((stuck_en && a_ra == 4'd5) ? 8'h04 : 8'h00);
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= 8'h00;
    end else begin
      if (b_we) mem_b[b_wa] <= b_wd;
      rd_b <= mem_b[b_ra];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor selection and scoreboards.
  bit sel;
  bit mon_en;
  logic       m_busy, m_done, m_fail, m_we;
  logic [3:0] m_ra, m_wa, m_fail_addr;
  logic [2:0] m_fail_elem;
  logic [7:0] m_wd, m_fail_data;
  assign m_busy      = sel ? b_busy : a_busy;
  assign m_done      = sel ? b_done : a_done;
  assign m_fail      = sel ? b_fail : a_fail;
  assign m_we        = sel ? b_we : a_we;
  assign m_ra        = sel ? b_ra : a_ra;
  assign m_wa        = sel ? b_wa : a_wa;
  assign m_wd        = sel ? b_wd : a_wd;
  assign m_fail_addr = sel ? b_fail_addr : a_fail_addr;
  assign m_fail_elem = sel ? b_fail_elem : a_fail_elem;
  assign m_fail_data = sel ? b_fail_data : a_fail_data;

  logic [11:0] exp_w[$];
  logic [3:0]  exp_ra[$];

  task automatic push_exp(input logic [7:0] p);
    logic [3:0] av;
    for (int a = 0; a < 16; a++) begin
      av = 4'(a);
      exp_w.push_back({av, p});
    end
    for (int e = 1; e <= 5; e++) begin
      for (int i = 0; i < 16; i++) begin
        av = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
        exp_ra.push_back(av);
        if (e <= 4) exp_w.push_back({av, (e == 1 || e == 3) ? ~p : p});
      end
    end
  endtask

  int t = 0;
  always @(negedge clk) begin
    if (mon_en && m_busy) begin
      if (m_we) begin
        check("wr_pending", 64'(exp_w.size() > 0), 64'(1));
        if (exp_w.size() > 0) check("wr_addr_data", 64'({m_wa, m_wd}), 64'(exp_w.pop_front()));
      end
      if (t >= 16 && ((t - 16) % 2) == 0) begin
        check("rd_pending", 64'(exp_ra.size() > 0), 64'(1));
        if (exp_ra.size() > 0) check("ra_seq", 64'(m_ra), 64'(exp_ra.pop_front()));
      end
      t++;
    end else if (!m_busy) begin
      t = 0;
    end
  end

  task automatic run_one(input bit s, input int repulse_at, input int rst_at,
                         output int bc, output int wc, output bit got_done);
    sel = s;
    bc = 0;
    wc = 0;
    got_done = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("accept_busy", 64'(m_busy), 64'(1));
    check("accept_done_clr", 64'(m_done), 64'(0));
    check("accept_fail_clr", 64'(m_fail), 64'(0));
    check("accept_fcap_clr", 64'({m_fail_addr, m_fail_elem, m_fail_data}), 64'(0));
    for (int c = 0; c < 1000; c++) begin
      if (m_done) begin
        got_done = 1'b1;
        break;
      end
      if (m_busy) bc++;
      if (m_we) wc++;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(m_busy), 64'(0));
        check("rst_we", 64'(m_we), 64'(0));
        check("rst_done", 64'(m_done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      start_a = (!s && c == repulse_at);
      start_b = (s && c == repulse_at);
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic clean_run(input bit s, input logic [7:0] p, input int repulse_at);
    int bc, wc;
    bit gd;
    push_exp(p);
    mon_en = 1'b1;
    run_one(s, repulse_at, -1, bc, wc, gd);
    mon_en = 1'b0;
    check("done_seen", 64'(gd), 64'(1));
    check("busy_cycles", 64'(bc), 64'(176));
    check("we_cycles", 64'(wc), 64'(80));
    check("pass_fail", 64'(m_fail), 64'(0));
    check("wq_drained", 64'(exp_w.size()), 64'(0));
    check("rq_drained", 64'(exp_ra.size()), 64'(0));
    exp_w.delete();
    exp_ra.delete();
  endtask

  initial begin
    int bc, wc;
    bit gd;
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    clr = 1'b0;
    stuck_en = 1'b0;
    alias_en = 1'b0;
    mon_en = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state_a", 64'({a_busy, a_done, a_fail, a_we}), 64'(0));
    check("rst_addrs_a", 64'({a_ra, a_wa, a_fail_addr, a_fail_elem}), 64'(0));
    check("rst_data_a", 64'({a_wd, a_fail_data}), 64'(0));
    check("rst_state_b", 64'({b_busy, b_done, b_we}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run, then done holds with we low.
    clean_run(1'b0, 8'h00, -1);
    repeat (3) @(negedge clk);
    check("done_hold", 64'({a_done, a_busy, a_we}), 64'(3'b100));

    // Stuck-at-1 on bit 2 of address 5.
    stuck_en = 1'b1;
    run_one(1'b0, -1, -1, bc, wc, gd);
    stuck_en = 1'b0;
    check("stuck_done", 64'(gd), 64'(1));
    check("stuck_busy_cycles", 64'(bc), 64'(176));
    check("stuck_fail", 64'(a_fail), 64'(1));
    check("stuck_faddr", 64'(a_fail_addr), 64'(5));
    check("stuck_felem", 64'(a_fail_elem), 64'(1));
    check("stuck_fdata", 64'(a_fail_data), 64'(8'h04));

    // Restart after a failing run: captures clear on acceptance.
    clean_run(1'b0, 8'h00, -1);

    // Writes to address 11 land on address 3.
    alias_en = 1'b1;
    run_one(1'b0, -1, -1, bc, wc, gd);
    alias_en = 1'b0;
    check("alias_done", 64'(gd), 64'(1));
    check("alias_busy_cycles", 64'(bc), 64'(176));
    check("alias_fail", 64'(a_fail), 64'(1));
    check("alias_felem_in_set", 64'(a_fail_elem == 3'd1 || a_fail_elem == 3'd2), 64'(1));
    check("alias_faddr_in_set", 64'(a_fail_addr == 4'd3 || a_fail_addr == 4'd11), 64'(1));

    // start pulsed mid-run is ignored.
    clean_run(1'b0, 8'h00, 50);

    // Reset mid-run, then a fresh run completes normally.
    run_one(1'b0, -1, 90, bc, wc, gd);
    check("rst_run_busy_cycles", 64'(bc), 64'(91));
    clean_run(1'b0, 8'h00, -1);

    // Non-zero background: write data and the descending address walk.
    clean_run(1'b1, 8'hA5, -1);
    check("b_done", 64'(b_done), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
